aes_sbox_share_collector: RTL and testbench

- Receiving end of the masked S-box datapath. Recombines the SHARES output shares of the pipelined DOM S-box and checks the result against the unmasked AES S-box.
- Aligns each result with its unmasked input through a valid/data delay line, then buffers {X, Q, ok} records in a small FIFO behind a valid/ready interface.
- Sits after aes_box in the self-checking masked-S-box harness and in on-chip BIST.

---
 rtl/aes_sbox_pkg.sv | 58 +++++
 rtl/share_result_fifo.sv | 55 +++++
 rtl/aes_sbox_share_collector.sv | 101 ++++++++++
 tb/tb_aes_sbox_share_collector.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/aes_sbox_pkg.sv
// Shared types and helpers for the masked S-box result collector: forward AES S-box,
// share slicing and the stored result record.
package aes_sbox_pkg;

    // Widest share bus the slice helper accepts.
    localparam int unsigned MaxShares = 16;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] q;
        logic       ok;
    } shareRecT;

    function automatic logic [7:0] sbox_f(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] shareSlice(input logic [8*MaxShares-1:0] bus,
                                              input int unsigned idx);
        return bus[8*idx +: 8];
    endfunction

endpackage

// File: rtl/share_result_fifo.sv
// Synchronous FIFO of result records. Head reads zero while empty; a push into a full
// FIFO is only accepted when a pop frees a slot in the same cycle.
module share_result_fifo
    import aes_sbox_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic     ClkxCI,
    input  logic     RstxRI,
    input  logic     PushxSI,
    input  shareRecT PushRecxDI,
    input  logic     PopxSI,
    output shareRecT HeadRecxDO,
    output logic     FullxSO,
    output logic     EmptyxSO
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

    shareRecT        mem [DEPTH];
    logic [PtrW-1:0] rdPtrQ, wrPtrQ;
    logic [CntW-1:0] cntQ;
    logic            doPush, doPop;

    assign EmptyxSO = (cntQ == '0);
    assign FullxSO  = (cntQ == DepthCnt);
    assign doPop    = PopxSI & ~EmptyxSO;
    assign doPush   = PushxSI & (~FullxSO | doPop);

    always_ff @(posedge ClkxCI or posedge RstxRI) begin
        if (RstxRI) begin
            rdPtrQ <= '0;
            wrPtrQ <= '0;
            cntQ   <= '0;
        end else begin
            if (doPush) wrPtrQ <= wrPtrQ + PtrW'(1);
            if (doPop)  rdPtrQ <= rdPtrQ + PtrW'(1);
            case ({doPush, doPop})
                2'b10:   cntQ <= cntQ + CntW'(1);
                2'b01:   cntQ <= cntQ - CntW'(1);
                default: cntQ <= cntQ;
            endcase
        end
    end

    // Storage needs no reset: nothing is visible until the count says so.
    always_ff @(posedge ClkxCI) begin
        if (doPush) mem[wrPtrQ] <= PushRecxDI;
    end

    assign HeadRecxDO = EmptyxSO ? '0 : mem[rdPtrQ];

endmodule

// File: rtl/aes_sbox_share_collector.sv
// Recombines masked S-box output shares, checks them against the unmasked S-box of the
// delayed input byte, and queues {X, Q, ok} records behind a valid/ready interface.
module aes_sbox_share_collector
    import aes_sbox_pkg::*;
#(
    parameter int unsigned SHARES     = 2,
    parameter int unsigned LATENCY    = 4,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                ClkxCI,
    input  logic                RstxRI,
    input  logic                InValidxSI,
    input  logic [7:0]          InXxDI,
    input  logic [8*SHARES-1:0] _QxDI,
    output logic                OutValidxSO,
    input  logic                OutReadyxSI,
    output logic [7:0]          OutXxDO,
    output logic [7:0]          OutQxDO,
    output logic                OutOkxSO,
    output logic [CNT_W-1:0]    ErrCntxDO,
    output logic                OverflowxSO
);

    logic                   validQ [LATENCY];
    logic [7:0]             xQ     [LATENCY];
    logic                   tapValid, tapOk;
    logic [7:0]             xTap, qComb;
    logic [8*MaxShares-1:0] qBus;
    logic [CNT_W-1:0]       errCntQ;
    logic                   overflowQ;
    logic                   fifoFull, fifoEmpty;
    shareRecT               pushRec, headRec;

    // Delay line keeps each unmasked byte aligned with its shares at the tap.
    always_ff @(posedge ClkxCI or posedge RstxRI) begin
        if (RstxRI) begin
            for (int i = 0; i < LATENCY; i++) begin
                validQ[i] <= 1'b0;
                xQ[i]     <= '0;
            end
        end else begin
            validQ[0] <= InValidxSI;
            xQ[0]     <= InXxDI;
            for (int i = 1; i < LATENCY; i++) begin
                validQ[i] <= validQ[i-1];
                xQ[i]     <= xQ[i-1];
            end
        end
    end

    assign tapValid = validQ[LATENCY-1];
    assign xTap     = xQ[LATENCY-1];
    assign qBus     = (8*MaxShares)'(_QxDI);

    always_comb begin
        qComb = '0;
        for (int unsigned i = 0; i < SHARES; i++) begin
            qComb = qComb ^ shareSlice(qBus, i);
        end
    end

    assign tapOk   = (qComb == sbox_f(xTap));
    assign pushRec = '{x: xTap, q: qComb, ok: tapOk};

    always_ff @(posedge ClkxCI or posedge RstxRI) begin
        if (RstxRI) begin
            errCntQ   <= '0;
            overflowQ <= 1'b0;
        end else begin
            if (tapValid && !tapOk && errCntQ != {CNT_W{1'b1}}) begin
                errCntQ <= errCntQ + CNT_W'(1);
            end
            // A full FIFO is never empty, so the pop happens exactly when ready is high.
            if (tapValid && fifoFull && !OutReadyxSI) begin
                overflowQ <= 1'b1;
            end
        end
    end

    share_result_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) uFifo (
        .ClkxCI    (ClkxCI),
        .RstxRI    (RstxRI),
        .PushxSI   (tapValid),
        .PushRecxDI(pushRec),
        .PopxSI    (OutReadyxSI),
        .HeadRecxDO(headRec),
        .FullxSO   (fifoFull),
        .EmptyxSO  (fifoEmpty)
    );

    assign OutValidxSO = ~fifoEmpty;
    assign OutXxDO     = headRec.x;
    assign OutQxDO     = headRec.q;
    assign OutOkxSO    = headRec.ok;
    assign ErrCntxDO   = errCntQ;
    assign OverflowxSO = overflowQ;

endmodule

// File: tb/tb_aes_sbox_share_collector.sv
// Bench for aes_sbox_share_collector: directed scenarios plus random traffic, checked
// against a queue model that derives the S-box from GF(2^8) inversion and the affine map.
module tb_aes_sbox_share_collector;

    localparam int unsigned Shares = 2;
    localparam int unsigned Latency = 4;
    localparam int unsigned Depth = 4;
    localparam int unsigned CntW = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic                inValid;
    logic [7:0]          inX;
    logic [8*Shares-1:0] qShares;
    logic                outValid;
    logic                outReady;
    logic [7:0]          outX;
    logic [7:0]          outQ;
    logic                outOk;
    logic [CntW-1:0]     errCnt;
    logic                overflow;

    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;

    // Model state: queue of {x, q, ok}, mismatch count, sticky overflow.
    logic [16:0] refQ [$];
    int          refErr;
    bit          refOvf;
    bit          schedV   [64];
    logic [16:0] schedRec [64];

    always #5 clk = ~clk;

    aes_sbox_share_collector #(
        .SHARES    (Shares),
        .LATENCY   (Latency),
        .FIFO_DEPTH(Depth),
        .CNT_W     (CntW)
    ) dut (
        .ClkxCI     (clk),
        .RstxRI     (rst),
        .InValidxSI (inValid),
        .InXxDI     (inX),
        ._QxDI      (qShares),
        .OutValidxSO(outValid),
        .OutReadyxSI(outReady),
        .OutXxDO    (outX),
        .OutQxDO    (outQ),
        .OutOkxSO   (outOk),
        .ErrCntxDO  (errCnt),
        .OverflowxSO(overflow)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] refSbox(input logic [7:0] a);
        logic [7:0] inv = 8'h00;
        logic [7:0] s;
        for (int i = 1; i < 256; i++) begin
            if (gmul(a, 8'(i)) == 8'h01) inv = 8'(i);
        end
        s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        return s;
    endfunction

    function automatic logic [8*Shares-1:0] makeShares(input logic [7:0] q);
        logic [8*Shares-1:0] v;
        logic [7:0] acc = q;
        for (int i = 0; i < Shares - 1; i++) begin
            v[8*i +: 8] = 8'($urandom);
            acc = acc ^ v[8*i +: 8];
        end
        v[8*(Shares-1) +: 8] = acc;
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll();
        logic [16:0] head = '0;
        if (refQ.size() != 0) head = refQ[0];
        check("outValid", 32'(outValid), 32'(refQ.size() != 0));
        check("outX", 32'(outX), 32'(head[16:9]));
        check("outQ", 32'(outQ), 32'(head[8:1]));
        check("outOk", 32'(outOk), 32'(head[0]));
        check("errCnt", 32'(errCnt), 32'(refErr));
        check("overflow", 32'(overflow), 32'(refOvf));
    endtask

    // One clock cycle: drive byte and due shares, clock, update model, check.
    task automatic step(input bit v, input logic [7:0] x, input bit bad, input bit rdy);
        logic [7:0]  q;
        logic [16:0] tap;
        bit          tapV, full, popped;
        int unsigned slot;
        @(negedge clk);
        inValid  = v;
        inX      = x;
        outReady = rdy;
        if (v) begin
            q = refSbox(x) ^ {7'b0, bad};
            slot = (cyc + Latency) % 64;
            schedV[slot]   = 1'b1;
            schedRec[slot] = {x, q, q == refSbox(x)};
        end
        slot = cyc % 64;
        tapV = schedV[slot];
        tap  = schedRec[slot];
        qShares = tapV ? makeShares(tap[8:1]) : (8*Shares)'($urandom);
        @(posedge clk);
        full   = (refQ.size() == Depth);
        popped = rdy && (refQ.size() != 0);
        if (popped) void'(refQ.pop_front());
        if (tapV) begin
            if (!tap[0] && refErr < 65535) refErr++;
            if (!full || popped) refQ.push_back(tap);
            else refOvf = 1'b1;
        end
        schedV[slot] = 1'b0;
        cyc++;
        #1;
        checkAll();
    endtask

    task automatic clearModel();
        refQ.delete();
        refErr = 0;
        refOvf = 1'b0;
        for (int i = 0; i < 64; i++) schedV[i] = 1'b0;
    endtask

    // Reset asserted mid-cycle; outputs must clear without waiting for an edge.
    task automatic doReset();
        @(negedge clk);
        inValid = 1'b0;
        rst = 1'b1;
        #1;
        check("rstValid", 32'(outValid), 32'd0);
        check("rstX", 32'(outX), 32'd0);
        check("rstQ", 32'(outQ), 32'd0);
        check("rstOk", 32'(outOk), 32'd0);
        check("rstErrCnt", 32'(errCnt), 32'd0);
        check("rstOverflow", 32'(overflow), 32'd0);
        clearModel();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        inValid = 1'b0;
        inX = '0;
        qShares = '0;
        outReady = 1'b0;
        clearModel();
        repeat (2) @(negedge clk);
        checkAll();
        rst = 1'b0;

        // Single byte: first result appears Latency+1 cycles after input.
        step(1'b1, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b0, 1'b1);

        // Streaming with ready held high.
        step(1'b1, 8'h53, 1'b0, 1'b1);
        step(1'b1, 8'h01, 1'b0, 1'b1);
        step(1'b1, 8'hff, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b0, 1'b1);

        // Fault injection then a clean byte.
        step(1'b1, 8'h10, 1'b1, 1'b1);
        step(1'b1, 8'h20, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b0, 1'b1);

        // Fill to Depth, then push and pop in the same cycle while full.
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 8'h77, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b0, 1'b1);

        // Backpressure: five pushes into a four-entry FIFO.
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'ha0 + i), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b0, 1'b1);

        // Reset with three stored and two in flight.
        doReset();
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hc0 + i), i == 1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 8'hd0, 1'b1, 1'b0);
        step(1'b1, 8'hd1, 1'b0, 1'b0);
        doReset();
        for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b0, 1'b1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 2) != 0, 8'($urandom), $urandom_range(0, 7) == 0,
                 $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
